// File: rtl/irq_controller.sv
// Machine-mode interrupt controller: owns mstatus.MIE/MPIE, mie and mip, arbitrates
// pending sources and hands one request at a time to the trap logic via req/ack.
module irq_controller #(
  parameter int EXT_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_irq,
  input  logic        ext_irq,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic        trap_taken,
  input  logic        mret,
  output logic        irq_req,
  output logic [31:0] irq_cause
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HANDLER = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic                       irq_req_q, irq_req_d;
  logic [31:0]                irq_cause_q, irq_cause_d;
  logic                       mstatus_mie_q, mstatus_mie_d;
  logic                       mstatus_mpie_q, mstatus_mpie_d;
  logic [2:0]                 mie_en_q, mie_en_d;   // {MEIE, MTIE, MSIE}
  logic                       mip_msip_q, mip_msip_d;
  logic                       mip_mtip_q, mip_mtip_d;
  logic [EXT_SYNC_STAGES-1:0] sync_q, sync_d;

  logic       meip;
  logic [2:0] pending;
  logic       cond;
  logic [3:0] code;
  logic       wr_mstatus, wr_mie, wr_mip;
  logic       trap_entry;
  logic       unused_wdata;

  assign meip       = sync_q[EXT_SYNC_STAGES-1];
  assign pending    = mie_en_q & {meip, mip_mtip_q, mip_msip_q};
  assign cond       = mstatus_mie_q & (|pending);
  assign wr_mstatus = csr_we && (csr_addr == ADDR_MSTATUS);
  assign wr_mie     = csr_we && (csr_addr == ADDR_MIE);
  assign wr_mip     = csr_we && (csr_addr == ADDR_MIP);
  assign sync_d     = {sync_q[EXT_SYNC_STAGES-2:0], ext_irq};
  assign irq_req    = irq_req_q;
  assign irq_cause  = irq_cause_q;
  assign unused_wdata = ^{csr_wdata[31:12], csr_wdata[10:8], csr_wdata[6:4], csr_wdata[2:0]};

  // Priority encode: external > software > timer.
  always_comb begin
    if (pending[2]) begin
      code = 4'd11;
    end else if (pending[0]) begin
      code = 4'd3;
    end else begin
      code = 4'd7;
    end
  end

  // Next-state for the request FSM and the interrupt CSR bits.
  always_comb begin
    state_d        = state_q;
    irq_req_d      = irq_req_q;
    irq_cause_d    = irq_cause_q;
    trap_entry     = 1'b0;
    mie_en_d       = mie_en_q;
    mip_msip_d     = mip_msip_q;
    mip_mtip_d     = mip_mtip_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;

    case (state_q)
      ST_IDLE: begin
        if (cond) begin
          state_d     = ST_REQ;
          irq_req_d   = 1'b1;
          irq_cause_d = {1'b1, 27'd0, code};
        end else begin
          irq_req_d   = 1'b0;
        end
      end
      ST_REQ: begin
        if (trap_taken) begin
          state_d    = ST_HANDLER;
          irq_req_d  = 1'b0;
          trap_entry = 1'b1;
        end else if (!cond) begin
          state_d     = ST_IDLE;
          irq_req_d   = 1'b0;
          irq_cause_d = 32'd0;
        end else begin
          irq_req_d   = 1'b1;
        end
      end
      ST_HANDLER: begin
        irq_req_d = 1'b0;
        if (mret) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HANDLER;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        irq_req_d   = 1'b0;
        irq_cause_d = 32'd0;
      end
    endcase

    if (wr_mie) begin
      mie_en_d = {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
    end else begin
      mie_en_d = mie_en_q;
    end

    if (wr_mip) begin
      mip_msip_d = csr_wdata[3];
    end else begin
      mip_msip_d = mip_msip_q;
    end

    // Timer pulse beats a same-cycle clearing write; writing 1 never sets MTIP.
    if (timer_irq) begin
      mip_mtip_d = 1'b1;
    end else if (wr_mip && !csr_wdata[7]) begin
      mip_mtip_d = 1'b0;
    end else begin
      mip_mtip_d = mip_mtip_q;
    end

    if (mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (trap_entry) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (wr_mstatus) begin
      mstatus_mie_d  = csr_wdata[3];
      mstatus_mpie_d = csr_wdata[7];
    end else begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
    end
  end

  // CSR read mux; unmapped addresses read as zero.
  always_comb begin
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      ADDR_MIE:     csr_rdata = {20'd0, mie_en_q[2], 3'd0, mie_en_q[1], 3'd0, mie_en_q[0], 3'd0};
      ADDR_MIP:     csr_rdata = {20'd0, meip, 3'd0, mip_mtip_q, 3'd0, mip_msip_q, 3'd0};
      default:      csr_rdata = 32'd0;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      irq_req_q      <= 1'b0;
      irq_cause_q    <= 32'd0;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_en_q       <= 3'd0;
      mip_msip_q     <= 1'b0;
      mip_mtip_q     <= 1'b0;
      sync_q         <= '0;
    end else begin
      state_q        <= state_d;
      irq_req_q      <= irq_req_d;
      irq_cause_q    <= irq_cause_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_en_q       <= mie_en_d;
      mip_msip_q     <= mip_msip_d;
      mip_mtip_q     <= mip_mtip_d;
      sync_q         <= sync_d;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: driver updates a behavioural model and queues
// the expected post-edge outputs; a monitor pops and compares after every edge.
module tb_irq_controller;
  localparam int NS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        timer_irq, ext_irq, csr_we, trap_taken, mret;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, irq_cause;
  logic        irq_req;

  always #10 clk = ~clk;

  irq_controller #(.EXT_SYNC_STAGES(NS)) dut (
    .clk(clk), .rst(rst), .timer_irq(timer_irq), .ext_irq(ext_irq),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .trap_taken(trap_taken), .mret(mret), .irq_req(irq_req), .irq_cause(irq_cause)
  );

  typedef struct packed {
    logic        req;
    logic [31:0] cause;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: 0 = idle, 1 = request outstanding, 2 = in handler.
  bit        m_mie, m_mpie, m_sip, m_tip, m_req;
  bit [2:0]  m_en;
  bit [31:0] m_cause;
  int        m_state;
  bit        ext_hist[$];
  bit        ext_lvl;

  function automatic bit m_eip();
    return (ext_hist.size() >= NS) ? ext_hist[NS-1] : 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a == 12'h300) begin
      r[3] = m_mie; r[7] = m_mpie;
    end else if (a == 12'h304) begin
      r[3] = m_en[0]; r[7] = m_en[1]; r[11] = m_en[2];
    end else if (a == 12'h344) begin
      r[3] = m_sip; r[7] = m_tip; r[11] = m_eip();
    end
    return r;
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_sip = 0; m_tip = 0; m_req = 0;
    m_en = 3'd0; m_cause = 32'd0; m_state = 0;
    ext_hist.delete();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step(input bit t, input bit e, input bit we, input logic [11:0] a,
                      input logic [31:0] wd, input bit tk, input bit mr);
    bit ps, pt, pe, cond;
    bit [3:0] code;
    bit n_mie, n_mpie, n_sip, n_tip, n_req;
    bit [2:0] n_en;
    bit [31:0] n_cause;
    int n_state;
    @(negedge clk);
    timer_irq = t; ext_irq = e; csr_we = we; csr_addr = a; csr_wdata = wd;
    trap_taken = tk; mret = mr;

    ps = m_en[0] & m_sip;
    pt = m_en[1] & m_tip;
    pe = m_en[2] & m_eip();
    cond = m_mie && (ps || pt || pe);
    code = pe ? 4'd11 : (ps ? 4'd3 : 4'd7);
    n_mie = m_mie; n_mpie = m_mpie; n_sip = m_sip; n_tip = m_tip; n_en = m_en;
    n_req = m_req; n_cause = m_cause; n_state = m_state;

    if (we && a == 12'h300) begin n_mie = wd[3]; n_mpie = wd[7]; end
    if (we && a == 12'h304) n_en = {wd[11], wd[7], wd[3]};
    if (we && a == 12'h344) begin
      n_sip = wd[3];
      if (!wd[7]) n_tip = 0;
    end
    if (t) n_tip = 1;

    if (m_state == 0) begin
      if (cond) begin n_state = 1; n_req = 1; n_cause = 32'h8000_0000 | 32'(code); end
    end else if (m_state == 1) begin
      if (tk) begin
        n_state = 2; n_req = 0; n_mpie = m_mie; n_mie = 0;
      end else if (!cond) begin
        n_state = 0; n_req = 0; n_cause = 32'd0;
      end
    end else begin
      if (mr) n_state = 0;
    end
    if (mr) begin n_mie = m_mpie; n_mpie = 1; end

    m_mie = n_mie; m_mpie = n_mpie; m_sip = n_sip; m_tip = n_tip; m_en = n_en;
    m_req = n_req; m_cause = n_cause; m_state = n_state;
    ext_hist.push_front(e);
    while (ext_hist.size() > NS) void'(ext_hist.pop_back());
    exp_q.push_back('{req: m_req, cause: m_cause, rdata: m_read(a)});
  endtask

  task automatic idle(input int n, input logic [11:0] a);
    repeat (n) step(1'b0, ext_lvl, 1'b0, a, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    step(1'b0, ext_lvl, 1'b1, a, d, 1'b0, 1'b0);
  endtask

  // Monitor: compare DUT outputs with the oldest queued expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("irq_req", {31'd0, irq_req}, {31'd0, e.req});
        check("irq_cause", irq_cause, e.cause);
        check("csr_rdata", csr_rdata, e.rdata);
      end
    end
  end

  initial begin
    int guard;
    logic [11:0] ra;
    logic [31:0] wd;
    bit t, we, tk, mr;
    rst = 1'b1; timer_irq = 0; ext_irq = 0; csr_we = 0; csr_addr = 12'h300;
    csr_wdata = 32'd0; trap_taken = 0; mret = 0; ext_lvl = 0;
    model_reset();
    #3;
    check("reset_req", {31'd0, irq_req}, 32'd0);
    check("reset_cause", irq_cause, 32'd0);
    check("reset_mstatus", csr_rdata, 32'd0);
    csr_addr = 12'h304; #1;
    check("reset_mie", csr_rdata, 32'd0);
    csr_addr = 12'h344; #1;
    check("reset_mip", csr_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Timer path and handshake with re-entry.
    wr(12'h304, 32'h80);
    wr(12'h300, 32'h8);
    idle(3, 12'h344);
    step(1, 0, 0, 12'h344, 0, 0, 0);
    idle(3, 12'h300);
    step(0, 0, 0, 12'h300, 0, 1, 0);
    idle(2, 12'h300);
    step(0, 0, 0, 12'h300, 0, 0, 1);
    idle(3, 12'h300);
    // Clear MTIP in handler; then set/clear collision.
    step(0, 0, 0, 12'h344, 0, 1, 0);
    wr(12'h344, 32'h0);
    step(0, 0, 0, 12'h344, 0, 0, 1);
    idle(3, 12'h344);
    step(1, 0, 1, 12'h344, 32'h0, 0, 0);
    idle(2, 12'h344);
    // Priority with all three sources.
    step(0, 0, 0, 12'h300, 0, 1, 0);
    step(0, 0, 0, 12'h300, 0, 0, 1);
    wr(12'h300, 32'h0);
    wr(12'h304, 32'h888);
    step(1, 0, 1, 12'h344, 32'h8, 0, 0);
    ext_lvl = 1;
    idle(3, 12'h344);
    wr(12'h300, 32'h8);
    idle(3, 12'h344);
    ext_lvl = 0;
    idle(3, 12'h344);
    step(0, 0, 0, 12'h300, 0, 1, 0);
    idle(1, 12'h344);
    step(0, 0, 0, 12'h300, 0, 0, 1);
    idle(3, 12'h344);
    // Masking.
    wr(12'h300, 32'h0);
    wr(12'h304, 32'h80);
    step(1, 0, 0, 12'h344, 0, 0, 0);
    idle(3, 12'h344);
    wr(12'h300, 32'h8);
    idle(2, 12'h344);
    wr(12'h304, 32'h0);
    idle(3, 12'h304);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      t = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) ext_lvl = ~ext_lvl;
      we = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: ra = 12'h300;
        1: ra = 12'h304;
        2: ra = 12'h344;
        default: ra = 12'($urandom);
      endcase
      wd = $urandom;
      tk = (m_state == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      mr = !tk && ((m_state == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0));
      step(t, ext_lvl, we, ra, wd, tk, mr);
    end

    // Drive into the request state, then reset asynchronously.
    ext_lvl = 0;
    step(0, 0, 0, 12'h344, 0, 0, 1);
    wr(12'h304, 32'h80);
    wr(12'h300, 32'h8);
    step(1, 0, 0, 12'h344, 0, 0, 0);
    guard = 0;
    while (m_state != 1 && guard < 20) begin
      idle(1, 12'h344);
      guard++;
    end
    check("reach_req_state", 32'(m_state), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_req", {31'd0, irq_req}, 32'd0);
    check("async_rst_cause", irq_cause, 32'd0);
    check("async_rst_mip", csr_rdata, 32'd0);
    csr_addr = 12'h300; #1;
    check("async_rst_mstatus", csr_rdata, 32'd0);
    csr_addr = 12'h304; #1;
    check("async_rst_mie", csr_rdata, 32'd0);
    rst = 1'b0;
    model_reset();
    idle(3, 12'h344);
    wr(12'h304, 32'h80);
    wr(12'h300, 32'h8);
    step(1, 0, 0, 12'h344, 0, 0, 0);
    idle(3, 12'h344);

    @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
